// File: rtl/cam_pixel_packer_if.sv
// Camera-side stream, FIFO write port and status bundle of the pixel packer.
// master = packer side, slave = environment driving the camera/FIFO inputs.
interface cam_pixel_packer_if #(
    parameter int PIX_CNT_WIDTH  = 11,
    parameter int LINE_CNT_WIDTH = 10,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                      enable;
    logic                      cam_vsync;
    logic                      cam_href;
    logic [7:0]                cam_data;
    logic                      fifo_full;
    logic                      overflow_clr;
    logic                      fifo_write;
    logic [15:0]               fifo_data;
    logic                      frame_done;
    logic                      capturing;
    logic [LINE_CNT_WIDTH-1:0] line_count;
    logic [PIX_CNT_WIDTH-1:0]  last_line_pixels;
    logic                      overflow;
    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        input  enable, cam_vsync, cam_href, cam_data, fifo_full, overflow_clr,
        output fifo_write, fifo_data, frame_done, capturing, line_count,
               last_line_pixels, overflow, drop_count
    );

    modport slave (
        output enable, cam_vsync, cam_href, cam_data, fifo_full, overflow_clr,
        input  fifo_write, fifo_data, frame_done, capturing, line_count,
               last_line_pixels, overflow, drop_count
    );
endinterface

// File: rtl/cam_pixel_packer.sv
// Packs camera byte pairs into RGB565 words and writes them to the pixel FIFO,
// tracking per-frame line/pixel statistics and dropped pixels on FIFO full.
module cam_pixel_packer #(
    parameter int PIX_CNT_WIDTH  = 11,
    parameter int LINE_CNT_WIDTH = 10,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                  clk_write,
    input  logic                  rst_n,
    cam_pixel_packer_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WAIT_VFALL,
        ST_ACTIVE
    } state_t;

    state_t                    state_q;
    logic                      vsync_q;
    logic                      vsync_prev_q;
    logic                      href_q;
    logic                      href_prev_q;
    logic [7:0]                data_q;
    logic [7:0]                hi_q;
    logic                      phase_q;
    logic [PIX_CNT_WIDTH-1:0]  pix_cnt_q;
    logic [PIX_CNT_WIDTH-1:0]  last_line_pixels_q;
    logic [LINE_CNT_WIDTH-1:0] line_cnt_q;
    logic [LINE_CNT_WIDTH-1:0] line_count_q;
    logic                      fifo_write_q;
    logic [15:0]               fifo_data_q;
    logic                      frame_done_q;
    logic                      overflow_q;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q;
    logic [DROP_CNT_WIDTH-1:0] drop_count_d;

    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;

    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_fall  = ~href_q & href_prev_q;

    always_comb begin
        drop_count_d = drop_count_q;
        if (!(&drop_count_q)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            vsync_q            <= 1'b0;
            vsync_prev_q       <= 1'b0;
            href_q             <= 1'b0;
            href_prev_q        <= 1'b0;
            data_q             <= '0;
            hi_q               <= '0;
            phase_q            <= 1'b0;
            pix_cnt_q          <= '0;
            last_line_pixels_q <= '0;
            line_cnt_q         <= '0;
            line_count_q       <= '0;
            fifo_write_q       <= 1'b0;
            fifo_data_q        <= '0;
            frame_done_q       <= 1'b0;
            overflow_q         <= 1'b0;
            drop_count_q       <= '0;
        end else begin
            vsync_q      <= bus.cam_vsync;
            href_q       <= bus.cam_href;
            data_q       <= bus.cam_data;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
            fifo_write_q <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_q <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    // A frame already in progress is skipped until its end.
                    if (vsync_rise) begin
                        state_q <= ST_WAIT_VFALL;
                    end
                end
                ST_WAIT_VFALL: begin
                    if (vsync_fall) begin
                        state_q    <= ST_ACTIVE;
                        line_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        phase_q    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (vsync_rise) begin
                        line_count_q <= line_cnt_q;
                        frame_done_q <= 1'b1;
                        phase_q      <= 1'b0;
                        pix_cnt_q    <= '0;
                        state_q      <= bus.enable ? ST_WAIT_VFALL : ST_IDLE;
                    end else if (href_q) begin
                        if (!phase_q) begin
                            hi_q    <= data_q;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (!bus.fifo_full) begin
                                fifo_write_q <= 1'b1;
                                fifo_data_q  <= {hi_q, data_q};
                                pix_cnt_q    <= pix_cnt_q + 1'b1;
                            end else begin
                                overflow_q   <= 1'b1;
                                drop_count_q <= drop_count_d;
                            end
                        end
                    end else if (href_fall) begin
                        // An unpaired trailing byte is simply abandoned here.
                        last_line_pixels_q <= pix_cnt_q;
                        pix_cnt_q          <= '0;
                        line_cnt_q         <= line_cnt_q + 1'b1;
                        phase_q            <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Clear wins over a drop landing in the same cycle.
            if (bus.overflow_clr) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    assign bus.fifo_write       = fifo_write_q;
    assign bus.fifo_data        = fifo_data_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.capturing        = (state_q == ST_ACTIVE);
    assign bus.line_count       = line_count_q;
    assign bus.last_line_pixels = last_line_pixels_q;
    assign bus.overflow         = overflow_q;
    assign bus.drop_count       = drop_count_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer: table of single-line vectors inside one
// frame, plus hand-written sequences for frame control, reset and clear cases.
module tb_cam_pixel_packer;
    localparam int PW = 11;
    localparam int LW = 10;
    localparam int DW = 16;

    logic clk_write = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_write = ~clk_write;

    cam_pixel_packer_if #(.PIX_CNT_WIDTH(PW), .LINE_CNT_WIDTH(LW), .DROP_CNT_WIDTH(DW)) bus();

    cam_pixel_packer #(.PIX_CNT_WIDTH(PW), .LINE_CNT_WIDTH(LW), .DROP_CNT_WIDTH(DW)) dut (
        .clk_write (clk_write),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [3:0]  nbytes;
        logic [47:0] bytes;
        logic [2:0]  full_pix;
        logic [1:0]  exp_writes;
        logic [47:0] exp_data;
        logic [10:0] exp_llp;
        logic [1:0]  exp_drops;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [5];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          fd_count  = 0;
    int          fd_double = 0;
    logic        fd_prev   = 1'b0;
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q  [$];

    always @(posedge clk_write) cyc <= cyc + 1;

    always @(negedge clk_write) begin
        if (bus.fifo_write === 1'b1) begin
            wr_data_q.push_back(bus.fifo_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) begin
            fd_count++;
            if (fd_prev) fd_double++;
        end
        fd_prev = (bus.frame_done === 1'b1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_write);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic h, input logic full, input logic clr);
        @(negedge clk_write);
        bus.cam_data     = b;
        bus.cam_href     = h;
        bus.fifo_full    = full;
        bus.overflow_clr = clr;
    endtask

    // Four-byte line with FIFO never full, followed by idle cycles.
    task automatic simple_line(input logic [31:0] bytes);
        for (int j = 0; j < 4; j++) drive_byte(bytes[31-8*j -: 8], 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) drive_byte(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        @(negedge clk_write); bus.cam_vsync = 1'b1;
        step(4);
        bus.cam_vsync = 1'b0;
        step(4);
    endtask

    // fifo_full for pixel p must be present in the cycle byte 2p+2 is driven.
    task automatic table_line(input vec_t v, output int last_drive_cyc);
        logic full;
        int   p;
        last_drive_cyc = 0;
        for (int j = 0; j < int'(v.nbytes) + 4; j++) begin
            full = 1'b0;
            if (j >= 2) begin
                p = (j - 2) >> 1;
                if (p < 3) full = v.full_pix[p];
            end
            if (j < int'(v.nbytes)) drive_byte(v.bytes[47-8*j -: 8], 1'b1, full, 1'b0);
            else                    drive_byte(8'h00, 1'b0, full, 1'b0);
            if (j == int'(v.nbytes) - 1) last_drive_cyc = cyc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_write"}, 64'(bus.fifo_write), 64'd0);
        check({tag, "_fifo_data"}, 64'(bus.fifo_data), 64'd0);
        check({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
        check({tag, "_capturing"}, 64'(bus.capturing), 64'd0);
        check({tag, "_line_count"}, 64'(bus.line_count), 64'd0);
        check({tag, "_last_line_pixels"}, 64'(bus.last_line_pixels), 64'd0);
        check({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        check({tag, "_drop_count"}, 64'(bus.drop_count), 64'd0);
    endtask

    initial begin
        int          last_cyc;
        int          fd_before;
        int          bad;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] expw;

        bus.enable = 1'b0; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0;
        bus.cam_data = 8'h00; bus.fifo_full = 1'b0; bus.overflow_clr = 1'b0;

        vecs[0] = '{4'd4, 48'h1234_5678_0000, 3'b000, 2'd2, 48'h1234_5678_0000, 11'd2, 2'd0, 1'b0};
        vecs[1] = '{4'd6, 48'hAABB_CCDD_EEFF, 3'b010, 2'd2, 48'hAABB_EEFF_0000, 11'd2, 2'd1, 1'b1};
        vecs[2] = '{4'd5, 48'h0102_0304_0500, 3'b000, 2'd2, 48'h0102_0304_0000, 11'd2, 2'd1, 1'b1};
        vecs[3] = '{4'd4, 48'hA1B2_C3D4_0000, 3'b000, 2'd2, 48'hA1B2_C3D4_0000, 11'd2, 2'd1, 1'b1};
        vecs[4] = '{4'd6, 48'h1020_3040_5060, 3'b000, 2'd3, 48'h1020_3040_5060, 11'd3, 2'd1, 1'b1};

        // Reset state, during and after reset
        step(3);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        step(2);
        check_all_zero("after_reset");

        // Start a frame
        bus.enable = 1'b1;
        step(2);
        vsync_pulse();
        check("capturing_active", 64'(bus.capturing), 64'd1);

        // Table-driven lines within one frame
        for (int v = 0; v < 5; v++) begin
            wr_data_q.delete();
            wr_cyc_q.delete();
            table_line(vecs[v], last_cyc);
            $display("vec %0d: %0d bytes, %0d writes, last_line_pixels=%0d, drop_count=%0d",
                     v, vecs[v].nbytes, wr_data_q.size(), bus.last_line_pixels, bus.drop_count);
            check($sformatf("vec%0d_writes", v), 64'(wr_data_q.size()), 64'(vecs[v].exp_writes));
            for (int k = 0; k < int'(vecs[v].exp_writes); k++) begin
                if (k < wr_data_q.size())
                    check($sformatf("vec%0d_data%0d", v, k), 64'(wr_data_q[k]),
                          64'(vecs[v].exp_data[47-16*k -: 16]));
            end
            check($sformatf("vec%0d_llp", v), 64'(bus.last_line_pixels), 64'(vecs[v].exp_llp));
            check($sformatf("vec%0d_drops", v), 64'(bus.drop_count), 64'(vecs[v].exp_drops));
            check($sformatf("vec%0d_ovf", v), 64'(bus.overflow), 64'(vecs[v].exp_ovf));
            if (v == 0 && wr_cyc_q.size() == 2)
                check("latency_last_byte_to_write", 64'(wr_cyc_q[1] - last_cyc), 64'd2);
        end

        // Drop and clear in the same cycle: clear wins
        wr_data_q.delete();
        drive_byte(8'h55, 1'b1, 1'b0, 1'b0);
        drive_byte(8'h66, 1'b1, 1'b0, 1'b0);
        drive_byte(8'h00, 1'b0, 1'b1, 1'b1);
        drive_byte(8'h00, 1'b0, 1'b0, 1'b0);
        step(3);
        $display("clr_priority: %0d writes, overflow=%0d, drop_count=%0d",
                 wr_data_q.size(), bus.overflow, bus.drop_count);
        check("clr_prio_writes", 64'(wr_data_q.size()), 64'd0);
        check("clr_prio_overflow", 64'(bus.overflow), 64'd0);
        check("clr_prio_drop_count", 64'(bus.drop_count), 64'd0);
        check("clr_prio_llp", 64'(bus.last_line_pixels), 64'd0);

        // End of frame A (6 lines)
        fd_before = fd_count;
        @(negedge clk_write); bus.cam_vsync = 1'b1;
        step(5);
        $display("frame A end: line_count=%0d frame_done pulses=%0d", bus.line_count, fd_count - fd_before);
        check("frameA_done_pulses", 64'(fd_count - fd_before), 64'd1);
        check("frameA_line_count", 64'(bus.line_count), 64'd6);
        check("frameA_not_capturing", 64'(bus.capturing), 64'd0);

        // Frame B: 3 lines of 640 bytes
        bus.cam_vsync = 1'b0;
        step(4);
        check("frameB_capturing", 64'(bus.capturing), 64'd1);
        wr_data_q.delete();
        for (int l = 0; l < 3; l++) begin
            for (int j = 0; j < 640; j++) drive_byte(8'(j) ^ 8'(l * 7), 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) drive_byte(8'h00, 1'b0, 1'b0, 1'b0);
        end
        fd_before = fd_count;
        @(negedge clk_write); bus.cam_vsync = 1'b1;
        step(5);
        bad = 0;
        for (int k = 0; k < wr_data_q.size() && k < 960; k++) begin
            b0 = 8'(2 * (k % 320)) ^ 8'((k / 320) * 7);
            b1 = 8'(2 * (k % 320) + 1) ^ 8'((k / 320) * 7);
            expw = {b0, b1};
            if (wr_data_q[k] !== expw) bad++;
        end
        $display("frame B end: %0d writes, %0d data errors, line_count=%0d, last_line_pixels=%0d",
                 wr_data_q.size(), bad, bus.line_count, bus.last_line_pixels);
        check("frameB_writes", 64'(wr_data_q.size()), 64'd960);
        check("frameB_data_errors", 64'(bad), 64'd0);
        check("frameB_line_count", 64'(bus.line_count), 64'd3);
        check("frameB_llp", 64'(bus.last_line_pixels), 64'd320);
        check("frameB_done_pulses", 64'(fd_count - fd_before), 64'd1);

        // Enable dropped mid-frame: frame still completes, then IDLE
        bus.cam_vsync = 1'b0;
        step(4);
        bus.enable = 1'b0;
        wr_data_q.delete();
        simple_line(32'hDEAD_BEEF);
        check("en_drop_writes", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) check("en_drop_data1", 64'(wr_data_q[1]), 64'hBEEF);
        fd_before = fd_count;
        @(negedge clk_write); bus.cam_vsync = 1'b1;
        step(5);
        $display("enable dropped: frame_done pulses=%0d capturing=%0d line_count=%0d",
                 fd_count - fd_before, bus.capturing, bus.line_count);
        check("en_drop_done_pulses", 64'(fd_count - fd_before), 64'd1);
        check("en_drop_idle", 64'(bus.capturing), 64'd0);
        check("en_drop_line_count", 64'(bus.line_count), 64'd1);
        bus.cam_vsync = 1'b0;
        step(4);
        wr_data_q.delete();
        simple_line(32'h0BAD_F00D);
        check("idle_no_writes", 64'(wr_data_q.size()), 64'd0);

        // Enable asserted mid-frame (vsync already low): skip until next frame
        bus.enable = 1'b1;
        step(2);
        wr_data_q.delete();
        simple_line(32'h1111_2222);
        $display("mid-frame enable: %0d writes capturing=%0d", wr_data_q.size(), bus.capturing);
        check("midframe_no_writes", 64'(wr_data_q.size()), 64'd0);
        check("midframe_not_capturing", 64'(bus.capturing), 64'd0);
        vsync_pulse();
        wr_data_q.delete();
        simple_line(32'h3344_5566);
        check("midframe_next_writes", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            check("midframe_next_data0", 64'(wr_data_q[0]), 64'h3344);
            check("midframe_next_data1", 64'(wr_data_q[1]), 64'h5566);
        end

        // Async reset with half a pixel pending
        wr_data_q.delete();
        drive_byte(8'h11, 1'b1, 1'b0, 1'b0);
        drive_byte(8'h22, 1'b1, 1'b0, 1'b0);
        @(negedge clk_write);
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-pixel: fifo_write=%0d capturing=%0d", bus.fifo_write, bus.capturing);
        check_all_zero("async_reset");
        drive_byte(8'h33, 1'b1, 1'b0, 1'b0);
        drive_byte(8'h44, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) drive_byte(8'h50 + 8'(j), 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) drive_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check("post_reset_no_writes", 64'(wr_data_q.size()), 64'd0);
        check("post_reset_not_capturing", 64'(bus.capturing), 64'd0);
        check("post_reset_llp", 64'(bus.last_line_pixels), 64'd0);
        vsync_pulse();
        wr_data_q.delete();
        simple_line(32'h7788_99AA);
        $display("post-reset frame: %0d writes", wr_data_q.size());
        check("post_reset_frame_writes", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            check("post_reset_data0", 64'(wr_data_q[0]), 64'h7788);
            check("post_reset_data1", 64'(wr_data_q[1]), 64'h99AA);
        end

        check("frame_done_single_cycle", 64'(fd_double), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
